// File: rtl/twos_adder.sv
// twos_adder: registered N-bit ripple-carry adder/subtractor with carry and signed-overflow flags
module twos_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  input  logic         in_valid,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         out_valid
);
  logic [N-1:0] bx;
  logic [N-1:0] s;
  logic [N:0]   c;
  assign bx   = B ^ {N{c_in}};
  assign c[0] = c_in;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end
  // capture result on accepted operations, hold otherwise; valid pulses per accepted op
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s;
        c_out    <= c[N];
        overflow <= c[N] ^ c[N-1];
      end
    end
  end
endmodule

// File: tb/tb_twos_adder.sv
// tb_twos_adder: directed and exhaustive checks of twos_adder at N=4, random subset at N=8
module tb_twos_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       c_in, in_valid;
  logic [3:0] sum;
  logic       c_out, overflow, out_valid;
  logic [7:0] a8, b8;
  logic       c_in8, in_valid8;
  logic [7:0] sum8;
  logic       c_out8, overflow8, out_valid8;
  int tests = 0;
  int fails = 0;

  twos_adder #(.N(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .c_in(c_in), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .overflow(overflow), .out_valid(out_valid)
  );
  twos_adder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .c_in(c_in8), .in_valid(in_valid8),
    .sum(sum8), .c_out(c_out8), .overflow(overflow8), .out_valid(out_valid8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input int w, input int x, input int y, input bit c,
                                output int s, output bit co, output bit ov);
    int mask, half, full, sx, sy, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    full = x + (c ? (~y & mask) : y) + int'(c);
    s    = full & mask;
    co   = full[w];
    sx   = (x >= half) ? x - (1 << w) : x;
    sy   = (y >= half) ? y - (1 << w) : y;
    r    = c ? sx - sy : sx + sy;
    ov   = (r < -half) || (r >= half);
  endfunction

  task automatic step(input int x, input int y, input bit c, input bit v, input bit r);
    a = 4'(x); b = 4'(y); c_in = c; in_valid = v; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int s, input bit co, input bit ov, input bit v);
    chk({name, ".sum"}, int'(sum), s);
    chk({name, ".c_out"}, int'(c_out), int'(co));
    chk({name, ".overflow"}, int'(overflow), int'(ov));
    chk({name, ".out_valid"}, int'(out_valid), int'(v));
  endtask

  task automatic chk_model(input string name, input int x, input int y, input bit c);
    int s;
    bit co, ov;
    model(4, x, y, c, s, co, ov);
    chk_out(name, s, co, ov, 1'b1);
  endtask

  initial begin
    int s;
    bit co, ov;
    tbl[0]  = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'd1,  4'd0,  1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[2]  = '{4'd5,  4'd5,  1'b0, 4'b1010, 1'b0, 1'b1};
    tbl[3]  = '{4'd7,  4'd3,  1'b0, 4'b1010, 1'b0, 1'b1};
    tbl[4]  = '{4'd9,  4'd6,  1'b0, 4'b1111, 1'b0, 1'b0};
    tbl[5]  = '{4'd11, 4'd5,  1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[6]  = '{4'd0,  4'd0,  1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[7]  = '{4'd3,  4'd0,  1'b1, 4'b0011, 1'b1, 1'b0};
    tbl[8]  = '{4'd5,  4'd5,  1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{4'd7,  4'd3,  1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[10] = '{4'd9,  4'd6,  1'b1, 4'b0011, 1'b1, 1'b1};
    tbl[11] = '{4'd11, 4'd12, 1'b1, 4'b1111, 1'b0, 1'b0};
    a8 = '0; b8 = '0; c_in8 = 1'b0; in_valid8 = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step($urandom_range(15), $urandom_range(15), 1'($urandom_range(1)), 1'b1, 1'b1);
      chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
    end
    chk("reset8.sum", int'(sum8), 0);
    chk("reset8.out_valid", int'(out_valid8), 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].c, 1'b1, 1'b0);
      chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);
    end

    step(7, 3, 1'b0, 1'b1, 1'b0);
    chk_out("hold.load", 4'b1010, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(9, 6, 1'b1, 1'b0, 1'b0);
      chk_out($sformatf("hold%0d", i), 4'b1010, 1'b0, 1'b1, 1'b0);
    end

    step(5, 5, 1'b0, 1'b1, 1'b0);
    chk_out("b2b1", 4'b1010, 1'b0, 1'b1, 1'b1);
    step(11, 12, 1'b1, 1'b1, 1'b0);
    chk_out("b2b2", 4'b1111, 1'b0, 1'b0, 1'b1);
    step(11, 5, 1'b0, 1'b1, 1'b1);
    chk_out("b2b3", 0, 1'b0, 1'b0, 1'b0);
    step(9, 6, 1'b1, 1'b1, 1'b0);
    chk_out("b2b4", 4'b0011, 1'b1, 1'b1, 1'b1);
    step(3, 0, 1'b1, 1'b1, 1'b0);
    chk_out("b2b5", 4'b0011, 1'b1, 1'b0, 1'b1);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          step(x, y, 1'(c), 1'b1, 1'b0);
          chk_model($sformatf("exh_%0d_%0d_%0d", x, y, c), x, y, 1'(c));
        end

    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom_range(255));
      b8 = 8'($urandom_range(255));
      c_in8 = 1'($urandom_range(1));
      in_valid8 = 1'b1;
      model(8, int'(a8), int'(b8), c_in8, s, co, ov);
      @(posedge clk);
      #1;
      chk($sformatf("n8_%0d.sum", i), int'(sum8), s);
      chk($sformatf("n8_%0d.c_out", i), int'(c_out8), int'(co));
      chk($sformatf("n8_%0d.overflow", i), int'(overflow8), int'(ov));
      chk($sformatf("n8_%0d.out_valid", i), int'(out_valid8), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
